// File: rtl/regfile_dump_reader.sv
// Debug read-out engine: walks the register file through one spare read port and
// streams every captured 32-bit word as four bytes on a valid/ready byte interface.
module regfile_dump_reader #(
   parameter int unsigned FIRST_REG = 0,
   parameter int unsigned LAST_REG  = 31,
   parameter bit          MSB_FIRST = 1'b0
) (
   input  logic        clk,
   input  logic        clrn,
   input  logic        start,
   output logic [4:0]  rn,
   input  logic [31:0] q,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_SEND,
      S_DONE
   } state_t;

   localparam logic [4:0] FIRST_A = 5'(FIRST_REG);
   localparam logic [4:0] LAST_A  = 5'(LAST_REG);

   state_t      state_q, state_d;
   logic [4:0]  idx_q, idx_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] sreg_q, sreg_d;
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   // Byte order is fixed by MSB_FIRST; the shift register always presents the
   // next byte at the same end, so the send path needs no byte-select mux.
   function automatic logic [7:0] head_byte(input logic [31:0] w);
      return MSB_FIRST ? w[31:24] : w[7:0];
   endfunction

   function automatic logic [31:0] shift_out(input logic [31:0] w);
      return MSB_FIRST ? {w[23:0], 8'h00} : {8'h00, w[31:8]};
   endfunction

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q <= S_IDLE;
         idx_q   <= FIRST_A;
         cnt_q   <= 2'd0;
         sreg_q  <= 32'd0;
         data_q  <= 8'd0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         sreg_q  <= sreg_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      sreg_d  = sreg_q;
      data_d  = data_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               idx_d   = FIRST_A;
               busy_d  = 1'b1;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            // q is sampled only here, so later regfile writes cannot alter the word.
            sreg_d  = shift_out(q);
            data_d  = head_byte(q);
            valid_d = 1'b1;
            cnt_d   = 2'd0;
            state_d = S_SEND;
         end
         S_SEND: begin
            if (valid_q && out_ready) begin
               if (cnt_q != 2'd3) begin
                  cnt_d  = cnt_q + 2'd1;
                  data_d = head_byte(sreg_q);
                  sreg_d = shift_out(sreg_q);
               end else begin
                  valid_d = 1'b0;
                  if (idx_q == LAST_A) begin
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                     state_d = S_DONE;
                  end else begin
                     idx_d   = idx_q + 5'd1;
                     state_d = S_LOAD;
                  end
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign rn        = (state_q == S_LOAD) ? idx_q : FIRST_A;
   assign out_data  = data_q;
   assign out_valid = valid_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench: the stimulus side snapshots a register-file array into expected
// byte queues; independent monitors pop and compare on every accepted byte.
module tb_regfile_dump_reader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        clrn, start, start1, out_ready;
   logic [4:0]  rn, rn1;
   logic [31:0] q, q1;
   logic [7:0]  out_data, out_data1;
   logic        out_valid, out_valid1, busy, busy1, done, done1;

   logic [31:0] rf  [32];
   logic [31:0] rf1 [32];
   assign q  = rf[rn];
   assign q1 = rf1[rn1];

   regfile_dump_reader dut (
      .clk(clk), .clrn(clrn), .start(start), .rn(rn), .q(q),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .done(done)
   );

   regfile_dump_reader #(.FIRST_REG(5), .LAST_REG(5), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .clrn(clrn), .start(start1), .rn(rn1), .q(q1),
      .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready),
      .busy(busy1), .done(done1)
   );

   int nchecks = 0;
   int nerr = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int bytes0 = 0;
   int dones0 = 0;
   int dones1 = 0;
   int rmode = 0;
   bit timing_chk = 1'b0;
   bit first_seen = 1'b0;
   logic [7:0] exp0 [$];
   logic [7:0] exp1 [$];
   logic [7:0] got0 [$];
   logic [7:0] got1 [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      nchecks++;
      if (act !== req) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Ready patterns: 0 always ready, 1 repeating 1,0,0, 2 random.
   always @(posedge clk) begin
      #1;
      case (rmode)
         1:       out_ready = ((cyc % 3) == 0);
         2:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b1;
      endcase
   end

   logic       prev_stall = 1'b0;
   logic [7:0] prev_data = 8'd0;
   always @(negedge clk) begin
      if (!clrn) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'(prev_data));
         end
         if (out_valid && !first_seen) begin
            first_seen = 1'b1;
            if (timing_chk) check("first_valid_latency", 32'(cyc - acc_cyc), 32'd1);
         end
         if (out_valid && out_ready) begin
            got0.push_back(out_data);
            bytes0++;
            if (exp0.size() == 0) begin
               nchecks++;
               nerr++;
               $display("FAIL unexpected_byte: got %h expected none", out_data);
            end else begin
               check("byte", 32'(out_data), 32'(exp0.pop_front()));
            end
         end
         if (done) begin
            dones0++;
            check("done_queue_empty", 32'(exp0.size()), 32'd0);
            check("done_valid_low", 32'(out_valid), 32'd0);
            check("done_busy_low", 32'(busy), 32'd0);
            if (timing_chk) check("done_latency", 32'(cyc - acc_cyc), 32'd160);
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end
   end

   always @(negedge clk) begin
      if (clrn) begin
         if (out_valid1 && out_ready) begin
            got1.push_back(out_data1);
            if (exp1.size() == 0) begin
               nchecks++;
               nerr++;
               $display("FAIL unexpected_byte_msb: got %h expected none", out_data1);
            end else begin
               check("byte_msb", 32'(out_data1), 32'(exp1.pop_front()));
            end
         end
         if (done1) begin
            dones1++;
            check("done_msb_queue_empty", 32'(exp1.size()), 32'd0);
         end
      end
   end

   task automatic start0();
      logic [31:0] w;
      @(posedge clk);
      #1;
      start = 1'b1;
      bytes0 = 0;
      got0.delete();
      for (int k = 0; k < 32; k++) begin
         w = rf[k];
         for (int b = 0; b < 4; b++) exp0.push_back(w[8*b +: 8]);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      acc_cyc = cyc;
      first_seen = 1'b0;
   endtask

   task automatic wait_done0(input int budget);
      int d;
      int n;
      d = dones0;
      n = 0;
      while (dones0 == d && n < budget) begin
         @(posedge clk);
         n++;
      end
      check("dump_done", 32'(dones0 - d), 32'd1);
      repeat (2) @(posedge clk);
   endtask

   task automatic wait_bytes0(input int cnt);
      int n;
      n = 0;
      while (bytes0 < cnt && n < 2000) begin
         @(posedge clk);
         n++;
      end
      check("bytes_reached", 32'(bytes0 >= cnt), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w;
      int d;
      int n;
      clrn = 1'b0;
      start = 1'b0;
      start1 = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 32; k++) begin
         rf[k]  = 32'h1000_0000 + 32'(k);
         rf1[k] = $urandom;
      end
      rf1[5] = 32'hDEAD_BEEF;
      #12;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_rn", 32'(rn), 32'd0);
      check("rst_rn_msb", 32'(rn1), 32'd5);
      @(posedge clk);
      #1;
      clrn = 1'b1;
      repeat (2) @(posedge clk);

      // Full dump, always ready, with latency checks
      timing_chk = 1'b1;
      start0();
      @(negedge clk);
      check("busy_after_start", 32'(busy), 32'd1);
      wait_done0(400);
      timing_chk = 1'b0;
      check("bytes_full", 32'(bytes0), 32'd128);
      check("first_byte0", 32'(got0[0]), 32'h00);
      check("first_byte1", 32'(got0[1]), 32'h00);
      check("first_byte2", 32'(got0[2]), 32'h00);
      check("first_byte3", 32'(got0[3]), 32'h10);

      // Single-word MSB-first dump
      @(posedge clk);
      #1;
      start1 = 1'b1;
      w = rf1[5];
      for (int b = 3; b >= 0; b--) exp1.push_back(w[8*b +: 8]);
      @(posedge clk);
      #1;
      start1 = 1'b0;
      n = 0;
      while (dones1 == 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      check("msb_done", 32'(dones1), 32'd1);
      check("msb_count", 32'(got1.size()), 32'd4);
      if (got1.size() == 4)
         check("msb_word", {got1[0], got1[1], got1[2], got1[3]}, 32'hDEAD_BEEF);

      // Backpressure with the 1,0,0 ready pattern
      for (int k = 0; k < 32; k++) rf[k] = $urandom;
      rmode = 1;
      start0();
      wait_done0(1500);
      check("bytes_backpressure", 32'(bytes0), 32'd128);

      // Regfile write to reg[3] after it has been captured
      rmode = 2;
      for (int k = 0; k < 32; k++) rf[k] = $urandom;
      start0();
      wait_bytes0(13);
      rf[3] = 32'hFFFF_FFFF;
      wait_done0(1500);
      check("bytes_write_race", 32'(bytes0), 32'd128);

      // start pulses during SEND and during DONE are ignored
      rmode = 0;
      start0();
      wait_bytes0(50);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      d = dones0;
      n = 0;
      @(negedge clk);
      while (!done && n < 400) begin
         @(negedge clk);
         n++;
      end
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      check("one_done", 32'(dones0 - d), 32'd1);
      check("bytes_no_restart", 32'(bytes0), 32'd128);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_valid", 32'(out_valid), 32'd0);

      // Asynchronous reset in the middle of reg[10]
      rmode = 2;
      start0();
      wait_bytes0(41);
      @(posedge clk);
      #3;
      clrn = 1'b0;
      #1;
      check("abort_valid", 32'(out_valid), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_data", 32'(out_data), 32'd0);
      check("abort_rn", 32'(rn), 32'd0);
      exp0.delete();
      d = dones0;
      @(posedge clk);
      #3;
      clrn = 1'b1;
      repeat (20) @(posedge clk);
      check("abort_no_done", 32'(dones0 - d), 32'd0);
      rmode = 0;
      timing_chk = 1'b1;
      start0();
      wait_done0(400);
      timing_chk = 1'b0;
      check("bytes_after_abort", 32'(bytes0), 32'd128);

      check("final_queue0", 32'(exp0.size()), 32'd0);
      check("final_queue1", 32'(exp1.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
      $finish;
   end

endmodule
